leaf_out_arbiter: RTL and testbench

LEAF_OUT_ARBITER -- requirements
Module: leaf_out_arbiter

---
 rtl/leaf_out_arbiter.sv | 144 ++++++++++++++
 tb/tb_leaf_out_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_out_arbiter.sv
// Round-robin merge of NUM_REQ valid/ready word streams onto one output port.
// A grant lasts until MAX_BURST words are taken or the granted requester goes idle.
module leaf_out_arbiter #(
    parameter  int PAYLOAD_BITS = 32,
    parameter  int NUM_REQ      = 2,
    parameter  int MAX_BURST    = 16,
    localparam int SRC_BITS     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_BITS     = $clog2(MAX_BURST + 1)
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] in_V_TDATA,
    input  logic [NUM_REQ-1:0]              in_V_TVALID,
    output logic [NUM_REQ-1:0]              in_V_TREADY,
    output logic [PAYLOAD_BITS-1:0]         out_V_TDATA,
    output logic                            out_V_TVALID,
    input  logic                            out_V_TREADY,
    output logic [SRC_BITS-1:0]             out_src
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e                  state_q, state_d;
    logic [SRC_BITS-1:0]     gnt_q, gnt_d;
    logic [SRC_BITS-1:0]     ptr_q, ptr_d;
    logic [CNT_BITS-1:0]     burstCnt_q, burstCnt_d;
    logic                    outValid_q, outValid_d;
    logic [PAYLOAD_BITS-1:0] outData_q, outData_d;
    logic [SRC_BITS-1:0]     outSrc_q, outSrc_d;

    logic                    pickFound;
    logic [SRC_BITS-1:0]     pickIdx;
    logic [SRC_BITS-1:0]     cand;
    logic                    gntValid;
    logic                    downOk;
    logic                    xfer;
    logic                    pop;
    logic                    lastBeat;
    logic [PAYLOAD_BITS-1:0] gntWord;

    function automatic logic [SRC_BITS-1:0] wrapInc(input logic [SRC_BITS-1:0] idx);
        return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
    endfunction

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        pickFound = 1'b0;
        pickIdx   = ptr_q;
        cand      = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pickFound && in_V_TVALID[cand]) begin
                pickFound = 1'b1;
                pickIdx   = cand;
            end
            cand = wrapInc(cand);
        end
    end

    assign gntValid = in_V_TVALID[gnt_q];
    assign gntWord  = in_V_TDATA[int'(gnt_q)*PAYLOAD_BITS +: PAYLOAD_BITS];
    assign downOk   = !outValid_q || out_V_TREADY;
    assign xfer     = (state_q == GRANT) && gntValid && downOk;
    assign pop      = outValid_q && out_V_TREADY;
    assign lastBeat = (burstCnt_q == CNT_BITS'(MAX_BURST - 1));

    // Reset gating keeps ready low even before the first reset edge settles state.
    always_comb begin
        in_V_TREADY = '0;
        if (ap_rst_n && (state_q == GRANT) && downOk) begin
            in_V_TREADY[gnt_q] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        burstCnt_d = burstCnt_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outSrc_d   = outSrc_q;

        if (pop) begin
            outValid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pickFound) begin
                    gnt_d      = pickIdx;
                    burstCnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    outValid_d = 1'b1;
                    outData_d  = gntWord;
                    outSrc_d   = gnt_q;
                    burstCnt_d = burstCnt_q + 1'b1;
                    if (lastBeat) begin
                        state_d = IDLE;
                        ptr_d   = wrapInc(gnt_q);
                    end
                end else if (!gntValid) begin
                    // A stalled downstream never releases while the owner still has data.
                    state_d = IDLE;
                    ptr_d   = wrapInc(gnt_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            ptr_q      <= '0;
            burstCnt_q <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outSrc_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            burstCnt_q <= burstCnt_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outSrc_q   <= outSrc_d;
        end
    end

    assign out_V_TVALID = outValid_q;
    assign out_V_TDATA  = outData_q;
    assign out_src      = outSrc_q;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed scenarios plus randomized traffic for leaf_out_arbiter, checked
// against a transaction-level reference model and a per-requester scoreboard.
module tb_leaf_out_arbiter;

    localparam int PB = 32;
    localparam int NR = 2;
    localparam int MB = 4;

    logic             ap_clk;
    logic             ap_rst_n;
    logic [NR*PB-1:0] in_V_TDATA;
    logic [NR-1:0]    in_V_TVALID;
    logic [NR-1:0]    in_V_TREADY;
    logic [PB-1:0]    out_V_TDATA;
    logic             out_V_TVALID;
    logic             out_V_TREADY;
    logic [0:0]       out_src;

    leaf_out_arbiter #(
        .PAYLOAD_BITS(PB),
        .NUM_REQ     (NR),
        .MAX_BURST   (MB)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .in_V_TDATA  (in_V_TDATA),
        .in_V_TVALID (in_V_TVALID),
        .in_V_TREADY (in_V_TREADY),
        .out_V_TDATA (out_V_TDATA),
        .out_V_TVALID(out_V_TVALID),
        .out_V_TREADY(out_V_TREADY),
        .out_src     (out_src)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;

    // Each source presents consecutive words and holds a word until it is accepted.
    logic [31:0] srcNext[NR];
    int          srcLeft[NR];
    int          srcProb[NR];
    int          ordyProb;
    int          stallLeft;
    logic        rstN;

    // Reference model: owner is -1 while no grant is held.
    int          mOwner;
    int          mTaken;
    int          mPtr;
    bit          mOutValid;
    logic [31:0] mOutData;
    int          mOutSrc;

    logic [31:0] popNext[NR];
    logic [31:0] popWord[$];
    int          popSrc[$];
    int          popCyc[$];

    logic [31:0] sOutData;
    logic        sOutValid;
    logic [NR-1:0] sInRdy;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        ap_rst_n = rstN;
        for (int i = 0; i < NR; i++) begin
            in_V_TDATA[i*PB +: PB] = srcNext[i];
            in_V_TVALID[i] = (srcLeft[i] > 0) && (int'($urandom_range(99)) < srcProb[i]);
        end
        out_V_TREADY = (stallLeft > 0) ? 1'b0 : (int'($urandom_range(99)) < ordyProb);
    endtask

    task automatic modelReset();
        mOwner    = -1;
        mTaken    = 0;
        mPtr      = 0;
        mOutValid = 0;
        mOutData  = '0;
        mOutSrc   = 0;
    endtask

    task automatic modelUpdate(input logic [NR-1:0] vld, input logic ordy, input logic rst);
        bit xfer;
        bit pop;
        if (!rst) begin
            modelReset();
            return;
        end
        pop  = mOutValid && ordy;
        xfer = 0;
        if (mOwner < 0) begin
            for (int k = 0; k < NR; k++) begin
                int j;
                j = (mPtr + k) % NR;
                if (mOwner < 0 && vld[j]) begin
                    mOwner = j;
                    mTaken = 0;
                end
            end
        end else if (vld[mOwner] && (!mOutValid || ordy)) begin
            xfer      = 1;
            mOutData  = srcNext[mOwner];
            mOutSrc   = mOwner;
            mOutValid = 1;
            mTaken++;
            if (mTaken == MB) begin
                mPtr   = (mOwner + 1) % NR;
                mOwner = -1;
            end
        end else if (!vld[mOwner]) begin
            mPtr   = (mOwner + 1) % NR;
            mOwner = -1;
        end
        if (pop && !xfer) mOutValid = 0;
    endtask

    task automatic stepCycle();
        logic [NR-1:0] vld;
        logic [NR-1:0] acc;
        logic [NR-1:0] expRdy;
        logic          ordy;
        logic          rst;
        int            s;
        @(negedge ap_clk);
        vld = in_V_TVALID;
        ordy = out_V_TREADY;
        rst = ap_rst_n;
        sOutData = out_V_TDATA;
        sOutValid = out_V_TVALID;
        sInRdy = in_V_TREADY;
        expRdy = '0;
        if (rst && mOwner >= 0 && (!mOutValid || ordy)) expRdy[mOwner] = 1'b1;
        checkOutput("in_ready", in_V_TREADY, expRdy);
        checkOutput("ready_onehot", $countones(in_V_TREADY) <= 1, 1);
        checkOutput("out_valid", out_V_TVALID, mOutValid);
        checkOutput("out_data", out_V_TDATA, mOutData);
        checkOutput("out_src", out_src, mOutSrc);
        acc = in_V_TVALID & in_V_TREADY;
        if (rst && out_V_TVALID && out_V_TREADY) begin
            s = int'(out_src);
            checkOutput("stream_order", out_V_TDATA, popNext[s]);
            popNext[s]++;
            popWord.push_back(out_V_TDATA);
            popSrc.push_back(s);
            popCyc.push_back(cycle);
        end
        @(posedge ap_clk);
        cycle++;
        modelUpdate(vld, ordy, rst);
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) begin
                    srcNext[i]++;
                    srcLeft[i]--;
                end
            end
        end
        if (stallLeft > 0) stallLeft--;
        #1;
        applyStimulus();
    endtask

    task automatic clearLogs();
        popWord.delete();
        popSrc.delete();
        popCyc.delete();
    endtask

    task automatic startSrc(input int i, input logic [31:0] base, input int n, input int prob);
        srcNext[i] = base;
        srcLeft[i] = n;
        srcProb[i] = prob;
        popNext[i] = base;
    endtask

    task automatic doReset(input int n);
        rstN = 1'b0;
        for (int i = 0; i < NR; i++) srcLeft[i] = 0;
        ordyProb = 100;
        stallLeft = 0;
        applyStimulus();
        repeat (n) stepCycle();
        rstN = 1'b1;
        for (int i = 0; i < NR; i++) popNext[i] = srcNext[i];
        clearLogs();
        applyStimulus();
    endtask

    initial begin
        int s1Gap[6];
        logic [31:0] e0;
        int t;
        s1Gap = '{0, 1, 1, 1, 2, 1};
        rstN = 1'b0;
        ordyProb = 100;
        stallLeft = 0;
        for (int i = 0; i < NR; i++) begin
            srcNext[i] = '0;
            srcLeft[i] = 0;
            srcProb[i] = 100;
            popNext[i] = '0;
        end
        modelReset();
        applyStimulus();
        repeat (2) @(posedge ap_clk);
        #1;
        checkOutput("reset_out_valid", out_V_TVALID, 0);
        checkOutput("reset_out_data", out_V_TDATA, 0);
        checkOutput("reset_out_src", out_src, 0);
        checkOutput("reset_in_ready", in_V_TREADY, 0);

        $display("[TB] single requester burst");
        doReset(1);
        startSrc(0, 32'h10, 6, 100);
        applyStimulus();
        repeat (14) stepCycle();
        checkOutput("s1_count", popWord.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < popWord.size()) begin
                checkOutput($sformatf("s1_word%0d", k), popWord[k], 32'h10 + k);
                checkOutput($sformatf("s1_src%0d", k), popSrc[k], 0);
                if (k > 0) checkOutput($sformatf("s1_gap%0d", k), popCyc[k] - popCyc[k-1], s1Gap[k]);
            end
        end

        $display("[TB] two requesters alternating bursts");
        doReset(1);
        startSrc(0, 32'hA0, 12, 100);
        startSrc(1, 32'hB0, 12, 100);
        applyStimulus();
        repeat (20) stepCycle();
        checkOutput("s2_count", popWord.size() >= 12, 1);
        for (int k = 0; k < 12; k++) begin
            if (k < popWord.size()) begin
                if (k < 4) begin
                    checkOutput($sformatf("s2_word%0d", k), popWord[k], 32'hA0 + k);
                    checkOutput($sformatf("s2_src%0d", k), popSrc[k], 0);
                end else if (k < 8) begin
                    checkOutput($sformatf("s2_word%0d", k), popWord[k], 32'hB0 + k - 4);
                    checkOutput($sformatf("s2_src%0d", k), popSrc[k], 1);
                end else begin
                    checkOutput($sformatf("s2_word%0d", k), popWord[k], 32'hA4 + k - 8);
                    checkOutput($sformatf("s2_src%0d", k), popSrc[k], 0);
                end
                if (k > 0) checkOutput($sformatf("s2_gap%0d", k), popCyc[k] - popCyc[k-1], (k % 4 == 0) ? 2 : 1);
            end
        end

        $display("[TB] downstream back-pressure mid-burst");
        doReset(1);
        startSrc(0, 32'h30, 6, 100);
        applyStimulus();
        t = 0;
        while (t < 10 && popWord.size() < 2) begin
            stepCycle();
            t++;
        end
        checkOutput("s3_prefill", popWord.size(), 2);
        stallLeft = 5;
        applyStimulus();
        repeat (5) begin
            stepCycle();
            checkOutput("s3_hold_valid", sOutValid, 1);
            checkOutput("s3_hold_data", sOutData, 32'h32);
            checkOutput("s3_hold_rdy", sInRdy, 0);
        end
        repeat (12) stepCycle();
        checkOutput("s3_count", popWord.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < popWord.size()) checkOutput($sformatf("s3_word%0d", k), popWord[k], 32'h30 + k);
        end
        if (popWord.size() == 6) begin
            checkOutput("s3_burst_gap", popCyc[4] - popCyc[3], 2);
            checkOutput("s3_resume_gap", popCyc[5] - popCyc[4], 1);
        end

        $display("[TB] early release hands grant back");
        doReset(1);
        startSrc(1, 32'hC0, 2, 100);
        applyStimulus();
        stepCycle();
        startSrc(0, 32'hD0, 3, 100);
        applyStimulus();
        repeat (14) stepCycle();
        checkOutput("s4_count", popWord.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < popWord.size()) begin
                checkOutput($sformatf("s4_word%0d", k), popWord[k], (k < 2) ? 32'hC0 + k : 32'hD0 + k - 2);
                checkOutput($sformatf("s4_src%0d", k), popSrc[k], (k < 2) ? 1 : 0);
            end
        end
        if (popWord.size() >= 3) checkOutput("s4_release_gap", popCyc[2] - popCyc[1], 3);

        $display("[TB] reset in the middle of a burst");
        doReset(1);
        startSrc(0, 32'hE0, 20, 100);
        startSrc(1, 32'hF0, 20, 100);
        applyStimulus();
        repeat (3) stepCycle();
        checkOutput("s5_pre_valid", sOutValid, 1);
        rstN = 1'b0;
        applyStimulus();
        stepCycle();
        checkOutput("s5_rst_rdy_comb", sInRdy, 0);
        stepCycle();
        checkOutput("s5_rst_out_valid", sOutValid, 0);
        checkOutput("s5_rst_rdy", sInRdy, 0);
        rstN = 1'b1;
        for (int i = 0; i < NR; i++) popNext[i] = srcNext[i];
        e0 = srcNext[0];
        clearLogs();
        applyStimulus();
        repeat (10) stepCycle();
        checkOutput("s5_count", popWord.size() >= 4, 1);
        if (popWord.size() > 0) begin
            checkOutput("s5_first_src", popSrc[0], 0);
            checkOutput("s5_first_word", popWord[0], e0);
        end

        $display("[TB] randomized traffic");
        doReset(1);
        startSrc(0, $urandom, 150, 100);
        startSrc(1, $urandom, 150, 100);
        for (int blk = 0; blk < 8; blk++) begin
            srcProb[0] = int'($urandom_range(100, 20));
            srcProb[1] = int'($urandom_range(100, 20));
            ordyProb = int'($urandom_range(100, 30));
            if ($urandom_range(3) == 0) stallLeft = int'($urandom_range(6, 1));
            applyStimulus();
            repeat (50) stepCycle();
        end
        srcProb[0] = 100;
        srcProb[1] = 100;
        ordyProb = 100;
        applyStimulus();
        t = 0;
        while (t < 2000 && (srcLeft[0] > 0 || srcLeft[1] > 0 || out_V_TVALID)) begin
            stepCycle();
            t++;
        end
        checkOutput("drain_left0", srcLeft[0], 0);
        checkOutput("drain_left1", srcLeft[1], 0);
        checkOutput("drain_out_valid", out_V_TVALID, 0);
        for (int i = 0; i < NR; i++) begin
            checkOutput($sformatf("drain_all_popped%0d", i), popNext[i], srcNext[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
